// File: rtl/ble_uart_tx_arbiter_if.sv
// Bus bundle between the requesters/transmitter side (master) and the packet arbiter (slave).
// Handshake: a byte moves on req_data_in/req_last_in in any cycle where req_valid_in[i] && req_ready_out[i] at clk_in rising edge; valid must not depend on ready.
interface ble_uart_tx_arbiter_if #(
    parameter int NUM_REQ = 4
);
    localparam int GW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    logic [8*NUM_REQ-1:0] req_data_in;
    logic [NUM_REQ-1:0]   req_valid_in;
    logic [NUM_REQ-1:0]   req_last_in;
    logic [NUM_REQ-1:0]   req_ready_out;
    logic [7:0]           tx_data_out;
    logic                 tx_enable_out;
    logic                 tx_busy_in;
    logic                 tx_done_in;
    logic [GW-1:0]        grant_out;
    logic                 grant_valid_out;
    logic                 timeout_out;
    logic [1:0]           state_dbg;
    logic [GW-1:0]        rr_ptr_dbg;

    modport master (
        output req_data_in, req_valid_in, req_last_in, tx_busy_in, tx_done_in,
        input  req_ready_out, tx_data_out, tx_enable_out, grant_out, grant_valid_out,
               timeout_out, state_dbg, rr_ptr_dbg
    );

    modport slave (
        input  req_data_in, req_valid_in, req_last_in, tx_busy_in, tx_done_in,
        output req_ready_out, tx_data_out, tx_enable_out, grant_out, grant_valid_out,
               timeout_out, state_dbg, rr_ptr_dbg
    );
endinterface

// File: rtl/ble_uart_tx_arbiter.sv
// Round-robin packet arbiter feeding one ble_uart_tx; a grant is held for a whole packet
// and released on the last byte's done or after LOCK_TIMEOUT idle cycles in LOAD.
module ble_uart_tx_arbiter #(
    parameter  int NUM_REQ      = 4,
    parameter  int LOCK_TIMEOUT = 1024,
    localparam int TW           = $clog2(LOCK_TIMEOUT + 1)
) (
    input logic                clk_in,
    input logic                rst_in,
    ble_uart_tx_arbiter_if.slave bus
);
    localparam int GW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    typedef enum logic [1:0] {S_ARB, S_LOAD, S_SEND, S_WAIT} state_t;

    state_t        state;
    logic [GW-1:0] grant;
    logic [GW-1:0] rr_ptr;
    logic [GW-1:0] pick;
    logic          pick_ok;
    logic [TW-1:0] tmo_cnt;
    logic          last_q;
    logic          grant_valid;
    logic          tx_enable;
    logic [7:0]    tx_data;
    logic          timeout;

    // Index a + b modulo NUM_REQ, valid for 0 <= b < NUM_REQ.
    function automatic logic [GW-1:0] wrap_add(input logic [GW-1:0] a, input int b);
        int s;
        s = int'(a) + b;
        if (s >= NUM_REQ) s = s - NUM_REQ;
        return GW'(s);
    endfunction

    // Scan from the far end so the offset closest to rr_ptr wins.
    always_comb begin
        pick    = '0;
        pick_ok = 1'b0;
        for (int k = NUM_REQ - 1; k >= 0; k--) begin
            if (bus.req_valid_in[wrap_add(rr_ptr, k)]) begin
                pick    = wrap_add(rr_ptr, k);
                pick_ok = 1'b1;
            end
        end
    end

    always_comb begin
        bus.req_ready_out = '0;
        if (state == S_LOAD) bus.req_ready_out[grant] = bus.req_valid_in[grant];
    end

    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            state       <= S_ARB;
            rr_ptr      <= '0;
            grant       <= '0;
            grant_valid <= 1'b0;
            tx_enable   <= 1'b0;
            tx_data     <= 8'h00;
            timeout     <= 1'b0;
            tmo_cnt     <= '0;
            last_q      <= 1'b0;
        end else begin
            timeout <= 1'b0;
            case (state)
                S_ARB: begin
                    if (pick_ok) begin
                        grant       <= pick;
                        grant_valid <= 1'b1;
                        tmo_cnt     <= '0;
                        state       <= S_LOAD;
                    end
                end
                S_LOAD: begin
                    if (bus.req_valid_in[grant]) begin
                        tx_data   <= bus.req_data_in[{grant, 3'b000} +: 8];
                        last_q    <= bus.req_last_in[grant];
                        tmo_cnt   <= '0;
                        tx_enable <= 1'b1;
                        state     <= S_SEND;
                    end else if (tmo_cnt == TW'(LOCK_TIMEOUT - 1)) begin
                        timeout     <= 1'b1;
                        grant_valid <= 1'b0;
                        rr_ptr      <= wrap_add(grant, 1);
                        state       <= S_ARB;
                    end else begin
                        tmo_cnt <= tmo_cnt + TW'(1);
                    end
                end
                S_SEND: begin
                    // Enable stays up until the transmitter actually reports busy.
                    if (bus.tx_busy_in) begin
                        tx_enable <= 1'b0;
                        state     <= S_WAIT;
                    end
                end
                S_WAIT: begin
                    if (bus.tx_done_in) begin
                        if (last_q) begin
                            rr_ptr      <= wrap_add(grant, 1);
                            grant_valid <= 1'b0;
                            state       <= S_ARB;
                        end else begin
                            tmo_cnt <= '0;
                            state   <= S_LOAD;
                        end
                    end
                end
                default: state <= S_ARB;
            endcase
        end
    end

    assign bus.tx_data_out     = tx_data;
    assign bus.tx_enable_out   = tx_enable;
    assign bus.grant_out       = grant;
    assign bus.grant_valid_out = grant_valid;
    assign bus.timeout_out     = timeout;
    assign bus.state_dbg       = state;
    assign bus.rr_ptr_dbg      = rr_ptr;
endmodule
